led_uart_tx: RTL
================

Name: led_uart_tx

Overview:
- Debug output stage that sits directly downstream of the data memory's 8-bit LED register.
- Samples the LED byte every cycle, detects changes, and queues each new value in a small FIFO.
- Serialises queued bytes as 8N1 UART frames on a single pin, so LED writes made by firmware can be logged on a host without a logic analyser.
- Runs in the same clock domain as data memory, on the undivided oscillator clock, not the stall-gated processor clock.

Parameters:
- CLKS_PER_BIT, 52: clock cycles per UART bit (6 MHz / 115200 baud). Must be >= 2; elaboration error otherwise.
- FIFO_DEPTH, 4: byte entries in the change FIFO. Power of two, >= 2.

Ports:
- clk_i  input  1  system clock (oscillator clock, not the stall-gated processor clock)
- reset_i  input  1  asynchronous, active-high reset
- enable_i  input  1  1 = capture LED changes; 0 = ignore changes. A frame already queued or in flight still completes.
- led_i  input  8  LED byte from data memory's LED output
- tx_o  output  1  UART serial out, idle high
- busy_o  output  1  1 while the FSM is not IDLE or the FIFO is non-empty
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow_o  output  1  sticky flag: a change was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-high. It applies in any state, including mid-frame.
  - Outputs: tx_o=1, busy_o=0, fifo_count_o=0, overflow_o=0.
  - Internal: led_q=8'h00, FSM=IDLE; baud counter, bit index and FIFO pointers all cleared.
- Change detect:
  - led_q <= led_i on every edge, regardless of enable_i.
  - A push is requested on an edge where enable_i=1 and led_i != led_q.
  - At most one push per cycle. Repeated writes of the same value generate no traffic.
- FIFO (circular, write/read pointers one bit wider than the address):
  - Push when not full: store led_i, count+1.
  - Push when full and no pop in the same cycle: data dropped, overflow_o<=1. overflow_o holds until reset.
  - Push and pop in the same cycle: both succeed and count is unchanged, including when full. No overflow in that case.
  - Pop when empty: never issued by the FSM.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If count>0: pop, load the shift register, set tx_o<=0, baud counter<=0, go to START.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles, then tx_o<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, tx_o<=1 and go to STOP.
  - STOP: hold tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a change is sampled at edge E0 (FIFO written). The IDLE pop occurs at E1, and tx_o is low from E1 onward.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: one extra IDLE cycle (tx_o high) separates consecutive frames. The stop bit plus gap is CLKS_PER_BIT+1 cycles.
- busy_o is combinational from the state and count registers: (state != IDLE) || (count != 0).
- Arithmetic widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, compared against CLKS_PER_BIT-1.
  - Bit index: 3 bits.
  - No counter may wrap unobserved.
- enable_i deasserted mid-frame: the current frame and all queued bytes are still transmitted.
- tx_o is driven from a flop (glitch-free).

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single change: after reset, hold enable_i=1 and set led_i 00->A5 at edge E0.
  - tx_o low from E1 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Then high for 4 cycles; frame is 40 cycles total.
  - busy_o=1 from E0 until the return to IDLE; fifo_count_o goes 1 then 0 at E1.
- Back-to-back: drive led_i 01, 02, 03 on consecutive cycles.
  - Three frames decode as 01, 02, 03 in that order.
  - Each inter-frame high period is exactly 5 cycles.
  - overflow_o stays 0.
- Overflow: with the first frame in flight, push six distinct values (FIFO holds 4).
  - fifo_count_o saturates at 4 and overflow_o=1.
  - Host decodes the first byte plus the next 4 queued values; the 2 later values are dropped.
  - overflow_o stays 1 until reset.
- Full with simultaneous push/pop: FIFO full, and a new change arrives on the same edge the FSM pops.
  - fifo_count_o stays 4 and overflow_o stays 0.
  - The new byte is transmitted last.
- Duplicate and enable: write 5A twice, then write 5B with enable_i=0.
  - Exactly one frame (5A) is sent.
  - After enable_i=1, writing 5B again produces no frame, because led_q already tracked it.
- Reset mid-frame: assert reset_i during DATA bit 3.
  - tx_o=1, busy_o=0, fifo_count_o=0 immediately, without waiting for a clock.
  - After release, led_i=00 produces no frame.
  - Changing led_i to 7E produces a clean 7E frame.

Source files
------------

// File: rtl/led_uart_tx_if.sv
// LED-logger bus: capture controls in, UART line and FIFO status out.
interface led_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          enable_i;
    logic [7:0]                    led_i;
    logic                          tx_o;
    logic                          busy_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;
    logic                          overflow_o;

    modport master (
        output enable_i, led_i,
        input  tx_o, busy_o, fifo_count_o, overflow_o
    );

    modport slave (
        input  enable_i, led_i,
        output tx_o, busy_o, fifo_count_o, overflow_o
    );
endinterface

// File: rtl/led_uart_tx.sv
// Captures changes on the LED byte into a small FIFO and sends each one out
// as an 8N1 UART frame, so firmware LED writes can be logged on a host.
module led_uart_tx #(
    parameter int CLKS_PER_BIT = 52,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    led_uart_tx_if.slave   bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      led_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr, count;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tx_q, overflow_q;
    logic            full, push_req, pop, push_ok, baud_done;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign count     = wptr - rptr;
    assign full      = (count == PW'(FIFO_DEPTH));
    assign pop       = (state == IDLE) && (count != '0);
    assign push_req  = bus.enable_i && (bus.led_i != led_q);
    assign push_ok   = push_req && (!full || pop);
    assign baud_done = (baud == BAUD_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            led_q      <= 8'h00;
            wptr       <= '0;
            overflow_q <= 1'b0;
        end else begin
            led_q <= bus.led_i;
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (push_req && full && !pop)
                overflow_q <= 1'b1;
        end
    end

    // On a full push+pop the write lands in the slot being read; the pop
    // still sees the old byte because both are registered on the same edge.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wptr[AW-1:0]] <= bus.led_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            rptr    <= '0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift <= mem[rptr[AW-1:0]];
                        rptr  <= rptr + 1'b1;
                        tx_q  <= 1'b0;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        tx_q    <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_o         = tx_q;
    assign bus.busy_o       = (state != IDLE) || (count != '0);
    assign bus.fifo_count_o = count;
    assign bus.overflow_o   = overflow_q;
endmodule
